// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module      : cpu_types_pkg
// Description : Core-wide shared types (register index).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;
    localparam int REG_IDX_W = 5;
    typedef logic [REG_IDX_W-1:0] regbits_t;
endpackage

`default_nettype wire

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Types and constants for the pipeline hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;
    import cpu_types_pkg::*;

    localparam int REG_W_DEF = 5;
    localparam regbits_t ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        HALTED   = 2'd3
    } hazard_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic halted;
    } hz_ctl_t;

    localparam hz_ctl_t c_ctl_run  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam hz_ctl_t c_ctl_halt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
endpackage

`default_nettype wire

// File: rtl/hazard_unit_if.sv
// ============================================================================
// Module      : hazard_unit_if
// Description : Signal bundle for the hazard unit (hu = unit side, tb = driver).
//               Counter signals exist only when HAZARD_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_unit_if #(
    parameter int REG_W = hazard_pkg::REG_W_DEF,
    parameter int CNT_W = 32
) (
    input logic CLK
);
    logic             RST;
    logic             ihit;
    logic             dhit;
    logic [REG_W-1:0] dec_rs;
    logic [REG_W-1:0] dec_rt;
    logic             dec_uses_rt;
    logic             exe_memRd;
    logic [REG_W-1:0] exe_regDst;
    logic             mem_memRd;
    logic             mem_memWr;
    logic             mem_pcSrc;
    logic             wb_halt;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             halted;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] lu_stall_cnt;
    logic [CNT_W-1:0] mem_wait_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    modport hu (
        input  CLK, RST, ihit, dhit, dec_rs, dec_rt, dec_uses_rt, exe_memRd,
               exe_regDst, mem_memRd, mem_memWr, mem_pcSrc, wb_halt,
`ifdef HAZARD_PERF_EN
        output lu_stall_cnt, mem_wait_cnt, flush_cnt,
`endif
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted
    );

    modport tb (
        input  CLK,
        output RST, ihit, dhit, dec_rs, dec_rt, dec_uses_rt, exe_memRd,
               exe_regDst, mem_memRd, mem_memWr, mem_pcSrc, wb_halt,
`ifdef HAZARD_PERF_EN
        input  lu_stall_cnt, mem_wait_cnt, flush_cnt,
`endif
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted
    );
endinterface

`default_nettype wire

// File: rtl/hazard_perf_ctr.sv
// ============================================================================
// Module      : hazard_perf_ctr
// Description : Saturating event counter with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_perf_ctr #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;
endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// Module      : hazard_unit
// Description : Stall/flush control for the 5-stage pipeline (load-use,
//               D-mem wait, I-miss, branch flush, halt). Optional
//               performance counters enabled by HAZARD_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [REG_W-1:0] dec_rs,
    input  logic [REG_W-1:0] dec_rt,
    input  logic             dec_uses_rt,
    input  logic             exe_memRd,
    input  logic [REG_W-1:0] exe_regDst,
    input  logic             mem_memRd,
    input  logic             mem_memWr,
    input  logic             mem_pcSrc,
    input  logic             wb_halt,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted
);
    hazard_state_t r_state;
    hazard_state_t w_next_state;
    hz_ctl_t       w_ctl;
    hz_ctl_t       w_out;
    logic          w_dmem_wait;
    logic          w_load_use;
    logic          w_lu_fire;
    logic          w_wait_fire;
    logic          w_flush_fire;

    assign w_dmem_wait = (mem_memRd | mem_memWr) & ~dhit;
    assign w_load_use  = exe_memRd
                       & (exe_regDst != REG_W'(ZERO_REG))
                       & ((exe_regDst == dec_rs) | (dec_uses_rt & (exe_regDst == dec_rt)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_ctl        = c_ctl_run;
        w_next_state = r_state;
        w_lu_fire    = 1'b0;
        w_wait_fire  = 1'b0;
        w_flush_fire = 1'b0;
        if (r_state == HALTED) begin
            w_ctl = c_ctl_halt;
        end else begin
            w_next_state = RUN;
            if (w_dmem_wait) begin
                w_ctl        = '0;
                w_wait_fire  = 1'b1;
                w_next_state = MEM_WAIT;
            end else if (mem_pcSrc) begin
                // PC stays enabled so a missed target fetch is simply retried
                w_ctl.ifid_flush  = 1'b1;
                w_ctl.idex_flush  = 1'b1;
                w_ctl.exmem_flush = 1'b1;
                w_flush_fire      = 1'b1;
            end else if (w_load_use && (r_state != LU_STALL)) begin
                // The load has moved on to MEM after one bubble; EX fields are stale then
                w_ctl.pc_en      = 1'b0;
                w_ctl.ifid_en    = 1'b0;
                w_ctl.idex_flush = 1'b1;
                w_lu_fire        = 1'b1;
                w_next_state     = LU_STALL;
            end else if (!ihit) begin
                w_ctl.pc_en      = 1'b0;
                w_ctl.ifid_flush = 1'b1;
            end
            if (wb_halt) begin
                w_next_state = HALTED;
            end
        end
    end

    assign w_out = RST ? c_ctl_run : w_ctl;

    assign pc_en       = w_out.pc_en;
    assign ifid_en     = w_out.ifid_en;
    assign idex_en     = w_out.idex_en;
    assign exmem_en    = w_out.exmem_en;
    assign memwb_en    = w_out.memwb_en;
    assign ifid_flush  = w_out.ifid_flush;
    assign idex_flush  = w_out.idex_flush;
    assign exmem_flush = w_out.exmem_flush;
    assign halted      = w_out.halted;

`ifdef HAZARD_PERF_EN
    // Fire strobes are never raised in HALTED, so the counters freeze there
    hazard_perf_ctr #(.CNT_W(CNT_W)) u_lu_ctr (
        .clk     (CLK),
        .rst     (RST),
        .i_inc   (w_lu_fire),
        .o_count (lu_stall_cnt)
    );

    hazard_perf_ctr #(.CNT_W(CNT_W)) u_wait_ctr (
        .clk     (CLK),
        .rst     (RST),
        .i_inc   (w_wait_fire),
        .o_count (mem_wait_cnt)
    );

    hazard_perf_ctr #(.CNT_W(CNT_W)) u_flush_ctr (
        .clk     (CLK),
        .rst     (RST),
        .i_inc   (w_flush_fire),
        .o_count (flush_cnt)
    );
`else
    logic w_perf_unused;
    assign w_perf_unused = w_lu_fire ^ w_wait_fire ^ w_flush_fire;
`endif
endmodule

`default_nettype wire
